// File: rtl/pic_call_stack_if.sv
// Core <-> return-address stack bus: CALL/RETLW strobes in, stack status out.
interface pic_call_stack_if #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH+1)
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] top;
  logic [LW-1:0]    level;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  // core side
  modport master (output push, pop, din, err_clr,
                  input  top, level, empty, full, ovf, unf);
  // stack side
  modport slave  (input  push, pop, din, err_clr,
                  output top, level, empty, full, ovf, unf);
endinterface

// File: rtl/pic_call_stack.sv
// PIC16C5x-style return-address stack: shift-register LIFO, no trap on
// overflow/underflow, sticky debug flags and an occupancy count.
module pic_call_stack #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  pic_call_stack_if.slave bus
);

  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        ovf_q, ovf_d;
  logic                        unf_q, unf_d;
  logic                        ovf_set, unf_set;

  // next-state decode of push/pop; flag set events win over err_clr
  always_comb begin
    s_d     = s_q;
    level_d = level_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({bus.push, bus.pop})
      2'b10: begin
        // shift down; old bottom falls off, level saturates at DEPTH
        s_d[0] = bus.din;
        for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
        if (level_q != LVL_MAX) level_d = level_q + 1'b1;
        else                    ovf_set = 1'b1;
      end
      2'b01: begin
        // shift up; bottom entry keeps its value (duplicated), shift happens even when empty
        for (int i = 0; i < DEPTH-1; i++) s_d[i] = s_q[i+1];
        if (level_q != '0) level_d = level_q - 1'b1;
        else               unf_set = 1'b1;
      end
      2'b11: begin
        // replace top: pop then push of the same slot, depth unchanged
        s_d[0] = bus.din;
        if (level_q == '0) unf_set = 1'b1;
      end
      default: ;
    endcase
    ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
    unf_d = unf_set | (unf_q & ~bus.err_clr);
  end

  // state registers, synchronous reset has priority over all requests
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // top is readable in the same cycle as the pop that consumes it
  assign bus.top   = s_q[0];
  assign bus.level = level_q;
  assign bus.empty = (level_q == '0);
  assign bus.full  = (level_q == LVL_MAX);
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_pic_call_stack.sv
// Directed checks of the return-address stack in the PIC16C57 config
// (WIDTH=11, DEPTH=2) and a wider/deeper config (WIDTH=13, DEPTH=8).
module tb_pic_call_stack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pic_call_stack_if #(.WIDTH(11), .DEPTH(2)) a ();
  pic_call_stack_if #(.WIDTH(13), .DEPTH(8)) b ();

  pic_call_stack #(.WIDTH(11), .DEPTH(2)) u_a (.clk(clk), .rst(rst), .bus(a));
  pic_call_stack #(.WIDTH(13), .DEPTH(8)) u_b (.clk(clk), .rst(rst), .bus(b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock with the given request on the small stack, then idle inputs
  task automatic op_a(input logic pu, input logic po, input logic [10:0] d, input logic ec);
    a.push = pu; a.pop = po; a.din = d; a.err_clr = ec;
    @(posedge clk); #1;
    a.push = 1'b0; a.pop = 1'b0; a.din = '0; a.err_clr = 1'b0;
  endtask

  task automatic op_b(input logic pu, input logic po, input logic [12:0] d);
    b.push = pu; b.pop = po; b.din = d; b.err_clr = 1'b0;
    @(posedge clk); #1;
    b.push = 1'b0; b.pop = 1'b0; b.din = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_a(1'b0, 1'b0, 11'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    a.push = 1'b0; a.pop = 1'b0; a.din = '0; a.err_clr = 1'b0;
    b.push = 1'b0; b.pop = 1'b0; b.din = '0; b.err_clr = 1'b0;
    do_reset();

    // reset wins over a push, after the stack overflowed
    op_a(1'b1, 1'b0, 11'h001, 1'b0);
    op_a(1'b1, 1'b0, 11'h002, 1'b0);
    op_a(1'b1, 1'b0, 11'h003, 1'b0);
    chk("pre_rst_ovf", 32'(a.ovf), 32'd1);
    rst = 1'b1;
    op_a(1'b1, 1'b0, 11'h7FF, 1'b0);
    rst = 1'b0;
    chk("rst_top",   32'(a.top),   32'h0);
    chk("rst_level", 32'(a.level), 32'd0);
    chk("rst_empty", 32'(a.empty), 32'd1);
    chk("rst_full",  32'(a.full),  32'd0);
    chk("rst_ovf",   32'(a.ovf),   32'd0);
    chk("rst_unf",   32'(a.unf),   32'd0);

    // basic LIFO
    op_a(1'b1, 1'b0, 11'h123, 1'b0);
    chk("lifo_top1", 32'(a.top), 32'h123);
    op_a(1'b1, 1'b0, 11'h456, 1'b0);
    chk("lifo_top2",  32'(a.top),   32'h456);
    chk("lifo_full",  32'(a.full),  32'd1);
    chk("lifo_level", 32'(a.level), 32'd2);
    chk("lifo_ovf",   32'(a.ovf),   32'd0);
    op_a(1'b0, 1'b1, 11'h0, 1'b0);
    chk("lifo_pop1_top", 32'(a.top),   32'h123);
    chk("lifo_pop1_lvl", 32'(a.level), 32'd1);
    chk("lifo_pop1_full", 32'(a.full), 32'd0);
    op_a(1'b0, 1'b1, 11'h0, 1'b0);
    chk("lifo_pop2_lvl",   32'(a.level), 32'd0);
    chk("lifo_pop2_empty", 32'(a.empty), 32'd1);
    chk("lifo_pop2_unf",   32'(a.unf),   32'd0);

    // overflow drops the oldest entry; pops duplicate the bottom
    op_a(1'b1, 1'b0, 11'h001, 1'b0);
    op_a(1'b1, 1'b0, 11'h002, 1'b0);
    op_a(1'b1, 1'b0, 11'h003, 1'b0);
    chk("ovf_top",   32'(a.top),   32'h003);
    chk("ovf_level", 32'(a.level), 32'd2);
    chk("ovf_flag",  32'(a.ovf),   32'd1);
    op_a(1'b0, 1'b1, 11'h0, 1'b0);
    chk("ovf_pop1_top", 32'(a.top), 32'h002);
    op_a(1'b0, 1'b1, 11'h0, 1'b0);
    chk("ovf_pop2_top", 32'(a.top),   32'h002);
    chk("ovf_pop2_lvl", 32'(a.level), 32'd0);
    chk("ovf_sticky",   32'(a.ovf),   32'd1);
    op_a(1'b0, 1'b0, 11'h0, 1'b1);
    chk("ovf_clr", 32'(a.ovf), 32'd0);

    // underflow, clear, and set-beats-clear
    do_reset();
    op_a(1'b0, 1'b1, 11'h0, 1'b0);
    chk("unf_flag",  32'(a.unf),   32'd1);
    chk("unf_level", 32'(a.level), 32'd0);
    chk("unf_top",   32'(a.top),   32'h0);
    op_a(1'b0, 1'b0, 11'h0, 1'b1);
    chk("unf_clr", 32'(a.unf), 32'd0);
    op_a(1'b0, 1'b1, 11'h0, 1'b1);
    chk("unf_set_wins", 32'(a.unf), 32'd1);
    chk("unf_ovf_idle", 32'(a.ovf), 32'd0);

    // push+pop replaces the top only
    do_reset();
    op_a(1'b1, 1'b0, 11'h010, 1'b0);
    chk("rep_pre_top", 32'(a.top), 32'h010);
    op_a(1'b1, 1'b1, 11'h020, 1'b0);
    chk("rep_top",   32'(a.top),   32'h020);
    chk("rep_level", 32'(a.level), 32'd1);
    chk("rep_unf",   32'(a.unf),   32'd0);
    chk("rep_ovf",   32'(a.ovf),   32'd0);
    op_a(1'b0, 1'b1, 11'h0, 1'b0);
    chk("rep_below", 32'(a.top), 32'h0);
    op_a(1'b1, 1'b1, 11'h030, 1'b0);
    chk("rep_empty_top", 32'(a.top),   32'h030);
    chk("rep_empty_lvl", 32'(a.level), 32'd0);
    chk("rep_empty_unf", 32'(a.unf),   32'd1);

    // WIDTH=13, DEPTH=8
    for (int i = 0; i <= 8; i++) begin
      op_b(1'b1, 1'b0, 13'h1000 + 13'(i));
      if (i == 7) begin
        chk("b_full7", 32'(b.full), 32'd1);
        chk("b_ovf7",  32'(b.ovf),  32'd0);
      end
    end
    chk("b_level", 32'(b.level), 32'd8);
    chk("b_ovf",   32'(b.ovf),   32'd1);
    chk("b_top",   32'(b.top),   32'h1008);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b_pop%0d", k), 32'(b.top), 32'h1008 - 32'(k));
      op_b(1'b0, 1'b1, 13'h0);
    end
    chk("b_empty",   32'(b.empty), 32'd1);
    chk("b_unf_pre", 32'(b.unf),   32'd0);
    chk("b_pop8",    32'(b.top),   32'h1001);
    op_b(1'b0, 1'b1, 13'h0);
    chk("b_pop8_top", 32'(b.top),   32'h1001);
    chk("b_pop8_unf", 32'(b.unf),   32'd1);
    chk("b_pop8_lvl", 32'(b.level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
